// File: rtl/audio_pkg.sv
// audio_pkg: shared audio constants and the sample-to-I2S word conversion.
package audio_pkg;
  localparam int CLOCK_FREQ   = 50_000_000;
  localparam int AUDIO_FREQ   = 50_000;
  localparam int AUDIO_WORD_W = 16;
  localparam int SAMPLE_W     = 8;

  // Offset-binary to two's complement (flip MSB), left-justified in the word.
  function automatic logic [AUDIO_WORD_W-1:0] to_i2s_word(input logic [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0], {(AUDIO_WORD_W-SAMPLE_W){1'b0}}};
  endfunction
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO; push is ignored when full, pop is ignored when empty.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_level;
  logic          w_push, w_pop;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = r_level == LW'(DEPTH);
  assign o_empty = r_level == '0;
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  always_ff @(posedge clock)
    if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: mono I2S transmitter; FIFO-buffered 8-bit samples sent as
// left-justified 16-bit words on both channels, one sample per frame.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int BCLK_HALF  = 10,
  parameter int SLOT_BITS  = 25,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [SAMPLE_W-1:0]           sample,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata,
  output logic [7:0]                    underrun_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int CW = $clog2(BCLK_HALF);
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam int WW = $clog2(AUDIO_WORD_W);
  logic [CW-1:0]           r_cnt;
  logic [BW-1:0]           r_bit_idx;
  logic [AUDIO_WORD_W-1:0] r_word;
  logic [7:0]              r_underrun;
  logic                    r_bclk, r_lrclk, r_sdata;
  logic                    w_tick, w_fall, w_load, w_full, w_empty, w_bit;
  logic [BW-1:0]           w_bit_next, w_pos;
  logic [WW-1:0]           w_sel;
  logic [SAMPLE_W-1:0]     w_head;
  sample_fifo #(.DEPTH(FIFO_DEPTH), .W(SAMPLE_W)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (sample_valid),
    .i_pop   (w_load),
    .i_data  (sample),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );
  assign w_tick     = r_cnt == CW'(BCLK_HALF - 1);
  assign w_fall     = w_tick && r_bclk;
  assign w_bit_next = (r_bit_idx == BW'(2 * SLOT_BITS - 1)) ? '0 : r_bit_idx + 1'b1;
  assign w_load     = w_fall && w_bit_next == '0;
  assign w_pos      = (w_bit_next >= BW'(SLOT_BITS)) ? w_bit_next - BW'(SLOT_BITS) : w_bit_next;
  assign w_sel      = WW'(AUDIO_WORD_W - int'(w_pos));
  // Position 0 is the I2S one-bit delay; positions past the word pad with zeros.
  assign w_bit      = (w_pos == '0 || w_pos > BW'(AUDIO_WORD_W)) ? 1'b0 : r_word[w_sel];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_cnt      <= '0;
      r_bclk     <= 1'b0;
      r_bit_idx  <= BW'(2 * SLOT_BITS - 1);
      r_lrclk    <= 1'b1;
      r_sdata    <= 1'b0;
      r_word     <= '0;
      r_underrun <= '0;
    end else begin
      r_cnt  <= w_tick ? '0 : r_cnt + 1'b1;
      r_bclk <= w_tick ? ~r_bclk : r_bclk;
      if (w_fall) begin
        r_bit_idx <= w_bit_next;
        r_lrclk   <= w_bit_next >= BW'(SLOT_BITS);
        r_sdata   <= w_bit;
      end
      if (w_load) r_word <= w_empty ? '0 : to_i2s_word(w_head);
      if (w_load && w_empty && r_underrun != 8'hFF) r_underrun <= r_underrun + 1'b1;
    end
  assign sample_ready   = !w_full;
  assign bclk           = r_bclk;
  assign lrclk          = r_lrclk;
  assign sdata          = r_sdata;
  assign underrun_count = r_underrun;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed checks of framing, data, FIFO flow control, underrun and reset.
module tb_audio_i2s_tx;
  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       rs_n = 1'b1;
  logic [7:0] sample = '0;
  logic       sample_valid = 1'b0;
  logic       sample_ready, bclk, lrclk, sdata;
  logic [7:0] underrun_count;
  logic [2:0] fifo_level;
  logic       s_ready, s_bclk, s_lrclk, s_sdata;
  logic [7:0] s_underrun;
  logic [2:0] s_level;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  audio_i2s_tx dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .sample         (sample),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .bclk           (bclk),
    .lrclk          (lrclk),
    .sdata          (sdata),
    .underrun_count (underrun_count),
    .fifo_level     (fifo_level)
  );

  // Short-frame instance (136 clocks per frame) so saturation is reachable quickly.
  audio_i2s_tx #(.BCLK_HALF(2), .SLOT_BITS(17), .FIFO_DEPTH(4)) dut_small (
    .clock          (clock),
    .reset_n        (rs_n),
    .sample         (8'h00),
    .sample_valid   (1'b0),
    .sample_ready   (s_ready),
    .bclk           (s_bclk),
    .lrclk          (s_lrclk),
    .sdata          (s_sdata),
    .underrun_count (s_underrun),
    .fifo_level     (s_level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic go_to(input int t);
    if (t > cyc) begin
      repeat (t - cyc) @(posedge clock);
      #1;
      cyc = t;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out"}, {bclk, lrclk, sdata, sample_ready}, 4'b0101);
    chk({tag, "_und"}, underrun_count, 8'd0);
    chk({tag, "_lvl"}, fifo_level, 3'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk_reset_vals("async_rst");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cyc = 0;
  endtask

  // Checks {bclk, lrclk, sdata} at each BCLK rise across one frame.
  task automatic check_frame(input int start, input logic [15:0] word);
    logic [2:0] exp;
    int j;
    for (int n = 0; n < 50; n++) begin
      go_to(start + 20 * n + 10);
      j = n % 25;
      exp = {1'b1, n >= 25, (j >= 1 && j <= 16) ? word[16 - j] : 1'b0};
      chk($sformatf("frame%0d_bit%0d", start, n), {bclk, lrclk, sdata}, exp);
    end
  endtask

  task automatic idle_sequence();
    go_to(9);
    chk("bclk_pre_rise", bclk, 1'b0);
    go_to(10);
    chk("bclk_first_rise", bclk, 1'b1);
    go_to(19);
    chk("pre_fall", {bclk, lrclk, underrun_count}, {1'b1, 1'b1, 8'd0});
    go_to(20);
    chk("first_fall", {bclk, lrclk, sdata, underrun_count}, {1'b0, 1'b0, 1'b0, 8'd1});
    check_frame(20, 16'h0000);
    go_to(1019);
    chk("und_frame1", underrun_count, 8'd1);
    go_to(1020);
    chk("und_frame2", underrun_count, 8'd2);
    check_frame(1020, 16'h0000);
  endtask

  initial begin
    #1;
    // Idle after reset: every frame underruns and sdata stays low.
    do_reset();
    idle_sequence();

    // Single 0x40 sample before the first load -> 0xC000 on both slots.
    do_reset();
    sample = 8'h40;
    sample_valid = 1'b1;
    go_to(1);
    sample_valid = 1'b0;
    chk("b_level1", {fifo_level, sample_ready}, {3'd1, 1'b1});
    go_to(20);
    chk("b_popped", fifo_level, 3'd0);
    go_to(29);
    chk("b_bclk_low", bclk, 1'b0);
    check_frame(20, 16'hC000);
    chk("b_no_und", underrun_count, 8'd0);
    go_to(1020);
    chk("b_und_next", underrun_count, 8'd1);

    // Continuous valid: FIFO fills, then one pop per frame.
    do_reset();
    sample = 8'h01;
    sample_valid = 1'b1;
    go_to(1);
    sample = 8'h02;
    go_to(2);
    sample = 8'h03;
    go_to(3);
    chk("c_lvl3", {fifo_level, sample_ready}, {3'd3, 1'b1});
    sample = 8'h04;
    go_to(4);
    chk("c_full", {fifo_level, sample_ready}, {3'd4, 1'b0});
    sample = 8'h05;
    go_to(20);
    chk("c_pop1", {fifo_level, sample_ready}, {3'd3, 1'b1});
    go_to(21);
    chk("c_refill1", {fifo_level, sample_ready}, {3'd4, 1'b0});
    sample = 8'h06;
    check_frame(20, 16'h8100);
    go_to(1020);
    chk("c_pop2", {fifo_level, sample_ready}, {3'd3, 1'b1});
    go_to(1021);
    chk("c_refill2", {fifo_level, sample_ready}, {3'd4, 1'b0});
    sample = 8'h07;
    check_frame(1020, 16'h8200);
    check_frame(2020, 16'h8300);
    chk("c_no_und", underrun_count, 8'd0);
    sample_valid = 1'b0;

    // Push on the load edge of an empty FIFO: no bypass, frame underruns.
    do_reset();
    go_to(19);
    sample = 8'hC5;
    sample_valid = 1'b1;
    go_to(20);
    sample_valid = 1'b0;
    chk("d_und", {underrun_count, fifo_level}, {8'd1, 3'd1});
    check_frame(20, 16'h0000);
    go_to(1021);
    chk("d_loaded", {underrun_count, fifo_level}, {8'd1, 3'd0});
    check_frame(1020, 16'h4500);

    // Reset mid-slot with sdata high and three samples buffered.
    do_reset();
    sample = 8'h40;
    sample_valid = 1'b1;
    go_to(1);
    sample_valid = 1'b0;
    go_to(40);
    sample = 8'h11;
    sample_valid = 1'b1;
    go_to(41);
    sample = 8'h12;
    go_to(42);
    sample = 8'h13;
    go_to(43);
    sample_valid = 1'b0;
    go_to(45);
    chk("e_pre_reset", {fifo_level, lrclk, sdata}, {3'd3, 1'b0, 1'b1});
    do_reset();
    idle_sequence();

    // Underrun counter saturation on the short-frame instance.
    rs_n = 1'b0;
    #2;
    chk("s_rst_und", s_underrun, 8'd0);
    @(posedge clock);
    #1;
    rs_n = 1'b1;
    cyc = 0;
    go_to(3);
    chk("s_pre_load", s_underrun, 8'd0);
    go_to(4);
    chk("s_load1", {s_underrun, s_lrclk}, {8'd1, 1'b0});
    go_to(4 + 136 * 253);
    chk("s_load254", s_underrun, 8'd254);
    go_to(4 + 136 * 254);
    chk("s_load255", s_underrun, 8'd255);
    go_to(4 + 136 * 255);
    chk("s_load256", s_underrun, 8'd255);
    go_to(4 + 136 * 299);
    chk("s_load300", s_underrun, 8'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Mono I2S transmitter that drives the board audio codec from the music sample stream. It accepts 8-bit unsigned samples through a valid/ready handshake into a small FIFO. Each sample is converted to a left-justified 16-bit two's-complement word and serialized on BCLK/LRCLK/SDATA, with the same word sent on both channels. Frame rate is exactly 50 kHz at a 50 MHz clock, matching the music sample rate.

## Interface

Parameters:
- BCLK_HALF, 10: system clocks per BCLK half-period. BCLK = 2.5 MHz.
- SLOT_BITS, 25: BCLK periods per channel slot. Frame = 2·SLOT_BITS·2·BCLK_HALF = 1000 clocks.
- FIFO_DEPTH, 4: sample FIFO entries (power of two).

Ports:
- clock  input  1  system clock, 50 MHz
- reset_n  input  1  reset, asynchronous and active-low
- sample  input  8  unsigned audio sample
- sample_valid  input  1  sample is presented
- sample_ready  output  1  FIFO can accept; equals !full
- bclk  output  1  I2S bit clock
- lrclk  output  1  0 = left slot, 1 = right slot
- sdata  output  1  serial data, MSB first
- underrun_count  output  8  saturating count of frames started with an empty FIFO
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation

- Push into the FIFO when sample_valid && sample_ready.
- Word conversion: word[15:0] = {sample[7] ^ 1, sample[6:0], 8'h00}.
  - Example: 0x40 → 0xC000; 0x80 → 0x0000.
- Divider counter cnt runs 0..BCLK_HALF-1. At cnt == BCLK_HALF-1, bclk toggles and cnt returns to 0.
- A "fall event" is a toggle where bclk goes 1→0. All of bit_idx, lrclk, sdata and the frame word update only on fall events.
- bit_idx runs 0..2·SLOT_BITS-1 and wraps to 0. lrclk = (bit_idx >= SLOT_BITS). Slot position j = bit_idx mod SLOT_BITS.
- sdata by slot position:
  - j = 0: 0 (I2S one-bit delay).
  - j = 1..16: word[16-j].
  - j > 16: 0.
- Frame load happens on the fall event where bit_idx wraps to 0:
  - FIFO non-empty: pop the head and convert it into the frame word.
  - FIFO empty: frame word = 0x0000, and underrun_count increments, saturating at 255.
- No bypass: a push in the same cycle as a load-time pop on an empty FIFO does not satisfy the load. That frame underruns, and the pushed sample is kept for the next frame.
- Push and pop in the same cycle on a non-empty, non-full FIFO: level is unchanged.

## Timing

- Reset values (asynchronous assert):
  - Outputs: bclk = 0, lrclk = 1, sdata = 0, underrun_count = 0, fifo_level = 0, sample_ready = 1.
  - Internal: cnt = 0, bit_idx = 2·SLOT_BITS-1, frame word = 0, FIFO empty.
- Deassertion is synchronous to clock. The first rising BCLK edge comes BCLK_HALF clocks after release; the first fall event (bit_idx → 0, frame load) comes 2·BCLK_HALF clocks after release.
- Latency: a sample pushed at least 1 cycle before a load fall event has its MSB on sdata exactly one BCLK period after that event, at slot position j = 1.
- sample_ready deasserts the cycle after the push that fills the FIFO.
- Reset mid-frame: all outputs return to reset values at once and buffered samples are discarded.

## Structure

- Shared package audio_pkg:
  - CLOCK_FREQ = 50_000_000 and AUDIO_FREQ = 50_000.
  - AUDIO_WORD_W = 16 and SAMPLE_W = 8.
  - A to_i2s_word function for the conversion.
- Sub-module sample_fifo: parameterized synchronous FIFO with async active-low reset, push/pop/full/empty/level outputs.
- Top level holds the divider, bit counter, shift/word register and underrun counter.

## Test plan

- Reset release, no pushes: first fall event at cycle 20. lrclk falls to 0 there. sdata stays 0 throughout, and underrun_count reads 1 after the first frame and 2 after the second.
- Push 0x40 before the first load: the left slot carries sdata bits 1,1,0,0,0…, i.e. 0xC000 MSB-first starting one BCLK after lrclk falls. The right slot repeats the word, and bclk period is 20 clocks.
- Hold sample_valid high with 0x01, 0x02, …: sample_ready drops after 4 accepted. One sample pops per 1000-clock frame and ready reasserts the cycle after each pop, so successive frames carry 0x81xx, 0x82xx, …
- Push on the exact cycle of a load fall event with the FIFO empty: that frame sends 0x0000 and underrun increments. The next frame sends the pushed sample.
- Force 300 empty frames: underrun_count saturates at 255.
- Assert reset_n low mid-slot with the FIFO at level 3: outputs go to reset values asynchronously, fifo_level reads 0, and the post-release sequence is identical to the first scenario.
